ret_fsm: RTL and testbench

Return-sequence controller for the five-stage pipeline, and the counterpart of the call sequencer. On RET or RTI from decode it stalls fetch and injects stack-pop micro-instructions into the pipeline. It collects the popped words as they return from write-back, reassembles the 32-bit return address, and issues a one-cycle PC-change request. For RTI it also requests a flag restore.

---
 rtl/ret_fsm_pkg.sv | 23 ++
 rtl/ret_fsm.sv | 129 ++++++++++++
 tb/tb_ret_fsm.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ret_fsm_pkg.sv
// Shared pipeline constants for the return sequencer: injected opcodes, pop tags and FSM states.
package ret_fsm_pkg;

  localparam logic [15:0] PopFlagsOp  = 16'b0110100000001010;
  localparam logic [15:0] PopPcHighOp = 16'b0110100000001001;
  localparam logic [15:0] PopPcLowOp  = 16'b0110100000001000;
  localparam logic [15:0] NopOp       = 16'b0;

  // Tag codes carried back from memory/write-back with each popped word.
  localparam logic [1:0] TagFlags  = 2'b00;
  localparam logic [1:0] TagPcHigh = 2'b01;
  localparam logic [1:0] TagPcLow  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StPopFlags,
    StPopHigh,
    StPopLow,
    StWait,
    StChangePc
  } state_e;

endpackage

// File: rtl/ret_fsm.sv
// Return-sequence controller: injects stack pops on RET/RTI, reassembles the return address
// and issues a one-cycle PC change (plus flag restore for RTI).
module ret_fsm
  import ret_fsm_pkg::*;
#(
  parameter logic [15:0] POP_FLAGS_OP   = PopFlagsOp,
  parameter logic [15:0] POP_PC_HIGH_OP = PopPcHighOp,
  parameter logic [15:0] POP_PC_LOW_OP  = PopPcLowOp,
  parameter logic [15:0] NOP_OP         = NopOp
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ret,
  input  logic        rti,
  input  logic        pop_valid,
  input  logic [1:0]  pop_tag,
  input  logic [15:0] pop_data,
  output logic [15:0] out,
  output logic        stall,
  output logic [31:0] pc,
  output logic        change_pc_ret,
  output logic        flags_restore,
  output logic [3:0]  flags_out
);

  state_e      state_q, state_d;
  logic        is_rti_q, is_rti_d;
  logic        have_flags_q, have_flags_d;
  logic        have_high_q, have_high_d;
  logic        have_low_q, have_low_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] out_q, out_d;
  logic        stall_q;
  logic        change_pc_q;
  logic        flags_restore_q;

  always_comb begin
    state_d      = state_q;
    is_rti_d     = is_rti_q;
    have_flags_d = have_flags_q;
    have_high_d  = have_high_q;
    have_low_d   = have_low_q;
    pc_d         = pc_q;
    flags_d      = flags_q;

    // Captures are accepted in every busy state, including CHANGE_PC.
    if (pop_valid && (state_q != StIdle)) begin
      case (pop_tag)
        TagPcHigh: begin
          pc_d[31:16] = pop_data;
          have_high_d = 1'b1;
        end
        TagPcLow: begin
          pc_d[15:0] = pop_data;
          have_low_d = 1'b1;
        end
        TagFlags: begin
          flags_d      = pop_data[3:0];
          have_flags_d = 1'b1;
        end
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (ret || rti) begin
          is_rti_d     = rti;
          have_flags_d = 1'b0;
          have_high_d  = 1'b0;
          have_low_d   = 1'b0;
          state_d      = rti ? StPopFlags : StPopHigh;
        end
      end
      StPopFlags: state_d = StPopHigh;
      StPopHigh:  state_d = StPopLow;
      StPopLow:   state_d = StWait;
      StWait: begin
        if (have_high_d && have_low_d && (have_flags_d || !is_rti_q)) state_d = StChangePc;
      end
      StChangePc: state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    unique case (state_d)
      StPopFlags: out_d = POP_FLAGS_OP;
      StPopHigh:  out_d = POP_PC_HIGH_OP;
      StPopLow:   out_d = POP_PC_LOW_OP;
      default:    out_d = NOP_OP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      is_rti_q        <= 1'b0;
      have_flags_q    <= 1'b0;
      have_high_q     <= 1'b0;
      have_low_q      <= 1'b0;
      pc_q            <= '0;
      flags_q         <= '0;
      out_q           <= NOP_OP;
      stall_q         <= 1'b0;
      change_pc_q     <= 1'b0;
      flags_restore_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_rti_q        <= is_rti_d;
      have_flags_q    <= have_flags_d;
      have_high_q     <= have_high_d;
      have_low_q      <= have_low_d;
      pc_q            <= pc_d;
      flags_q         <= flags_d;
      out_q           <= out_d;
      stall_q         <= (state_d != StIdle);
      change_pc_q     <= (state_d == StChangePc);
      flags_restore_q <= (state_d == StChangePc) && is_rti_d;
    end
  end

  assign out           = out_q;
  assign stall         = stall_q;
  assign pc            = pc_q;
  assign change_pc_ret = change_pc_q;
  assign flags_restore = flags_restore_q;
  assign flags_out     = flags_q;

endmodule

// File: tb/tb_ret_fsm.sv
// Scoreboard bench for ret_fsm: directed scenarios plus randomized pop schedules.
module tb_ret_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        ret, rti, pop_valid;
  logic [1:0]  pop_tag;
  logic [15:0] pop_data;
  logic [15:0] out;
  logic        stall;
  logic [31:0] pc;
  logic        change_pc_ret;
  logic        flags_restore;
  logic [3:0]  flags_out;

  ret_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .ret          (ret),
    .rti          (rti),
    .pop_valid    (pop_valid),
    .pop_tag      (pop_tag),
    .pop_data     (pop_data),
    .out          (out),
    .stall        (stall),
    .pc           (pc),
    .change_pc_ret(change_pc_ret),
    .flags_restore(flags_restore),
    .flags_out    (flags_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        restore;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state: what the architectural pc/flags registers should hold.
  logic [31:0] m_pc    = '0;
  logic [3:0]  m_flags = '0;

  // Per-edge stimulus schedule for one transaction (edge 0 = request edge).
  localparam int Len = 20;
  bit          p_vld[Len];
  logic [1:0]  p_tag[Len];
  logic [15:0] p_dat[Len];
  bit          n_ret[Len];
  bit          n_rti[Len];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_pop(input logic [1:0] tag, input logic [15:0] data);
    case (tag)
      2'b01: m_pc[31:16] = data;
      2'b10: m_pc[15:0] = data;
      2'b00: m_flags = data[3:0];
      default: ;
    endcase
  endtask

  task automatic clear_sched();
    for (int e = 0; e < Len; e++) begin
      p_vld[e] = 0; p_tag[e] = 2'b11; p_dat[e] = '0; n_ret[e] = 0; n_rti[e] = 0;
    end
  endtask

  task automatic set_pop(input int e, input logic [1:0] tag, input logic [15:0] data);
    p_vld[e] = 1; p_tag[e] = tag; p_dat[e] = data;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (flags_restore && !change_pc_ret) begin
        n_total++;
        $display("FAIL restore_without_strobe: flags_restore=1 change_pc_ret=0 at cycle %0d", cyc);
      end
      if (change_pc_ret) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_strobe: change_pc_ret=1 at cycle %0d, none expected", cyc);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          check("strobe_cycle", cyc, x.cyc);
          check("strobe_pc", pc, x.pc);
          check("strobe_flags_restore", {31'b0, flags_restore}, {31'b0, x.restore});
          check("strobe_flags_out", {28'b0, flags_out}, {28'b0, x.flags});
        end
      end
    end
  end

  // Runs one request using the current schedule; edges 1..C+1 are the busy window.
  task automatic run_seq(input bit use_ret, input bit use_rti, input bit noise);
    bit          is_rti;
    int          fh, fl, ff, w, m, c, e0;
    logic [15:0] exp_out;
    exp_t        x;
    is_rti = use_rti;
    fh = 99; fl = 99; ff = 99;
    for (int e = 1; e < Len; e++) begin
      if (p_vld[e]) begin
        if (p_tag[e] == 2'b01 && fh == 99) fh = e;
        if (p_tag[e] == 2'b10 && fl == 99) fl = e;
        if (p_tag[e] == 2'b00 && ff == 99) ff = e;
      end
    end
    w = is_rti ? 4 : 3;
    m = (fh > fl) ? fh : fl;
    if (is_rti && ff > m) m = ff;
    c = (w > m) ? w : m;
    if (noise) begin
      int ne;
      ne = $urandom_range(c + 1, 1);
      n_ret[ne] = 1;
      n_rti[ne] = $urandom_range(1, 0) == 1;
    end
    for (int e = 1; e <= c; e++) if (p_vld[e]) apply_pop(p_tag[e], p_dat[e]);
    x.pc = m_pc; x.restore = is_rti; x.flags = m_flags;
    if (p_vld[c + 1]) apply_pop(p_tag[c + 1], p_dat[c + 1]);

    for (int e = 0; e < Len; e++) begin
      ret       = (e == 0) ? use_ret : n_ret[e];
      rti       = (e == 0) ? use_rti : n_rti[e];
      pop_valid = p_vld[e];
      pop_tag   = p_tag[e];
      pop_data  = p_dat[e];
      step();
      if (e == 0) begin
        e0 = cyc;
        x.cyc = e0 + c;
        sb_q.push_back(x);
      end
      if (is_rti) exp_out = (e == 0) ? 16'h680A : (e == 1) ? 16'h6809 : (e == 2) ? 16'h6808 : 16'h0;
      else exp_out = (e == 0) ? 16'h6809 : (e == 1) ? 16'h6808 : 16'h0;
      check("out_op", {16'b0, out}, {16'b0, exp_out});
      check("stall", {31'b0, stall}, {31'b0, (e <= c)});
    end
    ret = 0; rti = 0; pop_valid = 0; pop_tag = 2'b11; pop_data = '0;
    check("pc_hold", pc, m_pc);
    check("flags_hold", {28'b0, flags_out}, {28'b0, m_flags});
    clear_sched();
  endtask

  task automatic gen_random(input bit is_rti);
    bit got_h, got_l, got_f;
    int nx;
    clear_sched();
    got_h = 0; got_l = 0; got_f = !is_rti;
    for (int e = 0; e <= 12; e++) begin
      if ($urandom_range(2, 0) == 0) begin
        logic [1:0] t;
        t = 2'($urandom_range(3, 0));
        set_pop(e, t, 16'($urandom()));
        if (e >= 1 && t == 2'b01) got_h = 1;
        if (e >= 1 && t == 2'b10) got_l = 1;
        if (e >= 1 && t == 2'b00) got_f = 1;
      end
    end
    nx = 13;
    if (!got_h) begin set_pop(nx, 2'b01, 16'($urandom())); nx++; end
    if (!got_l) begin set_pop(nx, 2'b10, 16'($urandom())); nx++; end
    if (!got_f) set_pop(nx, 2'b00, 16'($urandom()));
  endtask

  initial begin
    reset = 1; ret = 0; rti = 0; pop_valid = 0; pop_tag = 2'b11; pop_data = '0;
    clear_sched();
    repeat (2) step();
    check("rst_out", {16'b0, out}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_change_pc", {31'b0, change_pc_ret}, 32'h0);
    check("rst_flags_restore", {31'b0, flags_restore}, 32'h0);
    check("rst_flags_out", {28'b0, flags_out}, 32'h0);
    @(negedge clk);
    reset = 0;
    step();

    // Async reset while parked in WAIT with pc partially captured.
    ret = 1; pop_valid = 1; pop_tag = 2'b01; pop_data = 16'hBEEF;
    step();
    ret = 0; pop_valid = 1; pop_tag = 2'b01; pop_data = 16'hBEEF;
    step();
    pop_valid = 0;
    repeat (2) step();
    #2 reset = 1;
    #1;
    check("async_rst_out", {16'b0, out}, 32'h0);
    check("async_rst_stall", {31'b0, stall}, 32'h0);
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_change_pc", {31'b0, change_pc_ret}, 32'h0);
    #2 reset = 0;
    m_pc = '0; m_flags = '0;
    repeat (8) step();

    // RET, both pops returned while waiting.
    set_pop(3, 2'b01, 16'h0012);
    set_pop(4, 2'b10, 16'h3456);
    run_seq(1, 0, 0);
    check("ret_pc_value", pc, 32'h00123456);

    // RTI with flags.
    set_pop(1, 2'b00, 16'h000B);
    set_pop(2, 2'b01, 16'hCAFE);
    set_pop(3, 2'b10, 16'hF00D);
    run_seq(0, 1, 0);
    check("rti_flags_value", {28'b0, flags_out}, 32'hB);

    // RET+RTI together, then another RET during WAIT.
    set_pop(5, 2'b00, 16'h0005);
    set_pop(6, 2'b01, 16'h1111);
    set_pop(7, 2'b10, 16'h2222);
    n_ret[5] = 1;
    run_seq(1, 1, 0);

    // Pop in IDLE first, then reversed arrival order.
    pop_valid = 1; pop_tag = 2'b01; pop_data = 16'hFFFF;
    step();
    pop_valid = 0;
    step();
    set_pop(1, 2'b10, 16'h5678);
    set_pop(2, 2'b01, 16'h9ABC);
    run_seq(1, 0, 0);
    check("reverse_pc_value", pc, 32'h9ABC5678);

    for (int i = 0; i < 40; i++) begin
      bit r_rti, r_both;
      r_rti  = $urandom_range(1, 0) == 1;
      r_both = r_rti && ($urandom_range(3, 0) == 0);
      gen_random(r_rti);
      run_seq(!r_rti || r_both, r_rti, $urandom_range(1, 0) == 1);
      repeat ($urandom_range(3, 0)) step();
    end

    repeat (4) step();
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
